// File: rtl/result_stream_out_pkg.sv
// Shared widths, FSM encoding and saturation limits for the result readback stream.
package result_stream_out_pkg;
   localparam int RESULT_W      = 32;
   localparam int ADDR_W        = 10;
   localparam int TENSOR_W      = 8;
   localparam int KERNEL_W      = 8;
   localparam int STRIDE_W      = 8;
   localparam int KERNEL_NUMS_W = 8;
   localparam int OUT_W_DEF     = 16;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_READ, S_DRAIN, S_FIN} state_t;

   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction
endpackage

// File: rtl/result_stream_out_sync_fifo.sv
// Small synchronous FIFO with combinational head output; push on full is accepted only alongside a pop.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/result_stream_out.sv
// Reads the result RAM after the convolution finishes, applies ReLU/saturation
// and streams the words out with a last marker and a completion pulse.
module result_stream_out
   import result_stream_out_pkg::*;
#(
   parameter int RESULT_SIZE = RESULT_W,
   parameter int OUT_WIDTH   = OUT_W_DEF,
   parameter int ADDR_SIZE   = ADDR_W,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic                     relu_en,
   input  logic [TENSOR_W-1:0]      tensor_size,
   input  logic [KERNEL_W-1:0]      kernel_size,
   input  logic [STRIDE_W-1:0]      stride,
   input  logic [KERNEL_NUMS_W-1:0] kernel_nums,
   output logic                     rd_en,
   output logic [ADDR_SIZE-1:0]     rd_addr,
   input  logic [RESULT_SIZE-1:0]   rd_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [OUT_WIDTH-1:0]     m_data,
   output logic                     m_last,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int NW = ADDR_SIZE + 1;
   localparam int PW = 2 * (TENSOR_W + 1) + KERNEL_NUMS_W;

   function automatic logic signed [RESULT_SIZE-1:0] relu(input logic signed [RESULT_SIZE-1:0] v,
                                                          input logic en);
      return (en && v < 0) ? '0 : v;
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [RESULT_SIZE-1:0] v);
      logic signed [63:0] w;
      w = 64'(v);
      if (w > sat_max(OUT_WIDTH)) return OUT_WIDTH'(sat_max(OUT_WIDTH));
      if (w < sat_min(OUT_WIDTH)) return OUT_WIDTH'(sat_min(OUT_WIDTH));
      return OUT_WIDTH'(w);
   endfunction

   state_t                   state, state_nxt;
   logic [TENSOR_W-1:0]      tensor_q, rem_q, quot_q;
   logic [KERNEL_W-1:0]      kernel_q;
   logic [STRIDE_W-1:0]      stride_q;
   logic [KERNEL_NUMS_W-1:0] kn_q;
   logic                     relu_q;
   logic [NW-1:0]            n_words, addr_q, out_cnt;
   logic                     cfg_err_q, vld_p1;
   logic [TENSOR_W:0]        out_dim;
   logic [PW-1:0]            prod;
   logic                     take, cfg_bad, div_step, n_bad, issue, pop, last_hs;
   logic [CW:0]              occupancy;
   logic signed [OUT_WIDTH-1:0] data_p1;
   logic [OUT_WIDTH-1:0]     fifo_head;
   logic                     fifo_full, fifo_empty;
   logic [CW-1:0]            fifo_count;

   assign take      = (state == S_IDLE) && start;
   assign cfg_bad   = (stride_q == '0) || (kernel_q > tensor_q);
   assign div_step  = (rem_q >= stride_q);
   assign out_dim   = (TENSOR_W+1)'(quot_q) + (TENSOR_W+1)'(1);
   assign prod      = PW'(out_dim) * PW'(out_dim) * PW'(kn_q);
   assign n_bad     = (kn_q == '0) || (prod > (PW'(1) << ADDR_SIZE));
   // Occupancy counts the read still in the RAM pipeline so the FIFO can never overflow.
   assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(vld_p1);
   assign issue     = (state == S_READ) && !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));

   assign m_valid   = !fifo_empty;
   assign m_data    = fifo_empty ? '0 : fifo_head;
   assign m_last    = m_valid && (out_cnt == n_words - NW'(1));
   assign pop       = m_valid && m_ready;
   assign last_hs   = pop && m_last;
   assign rd_addr   = addr_q[ADDR_SIZE-1:0];
   assign cfg_err   = cfg_err_q;

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      busy      = (state != S_IDLE);
      done      = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CALC;
         S_CALC: begin
            if (cfg_bad)        state_nxt = S_FIN;
            else if (!div_step) state_nxt = n_bad ? S_FIN : S_READ;
         end
         S_READ: begin
            rd_en = issue;
            if (issue && (addr_q == n_words - NW'(1))) state_nxt = S_DRAIN;
         end
         // The final handshake leaves the FIFO empty with nothing in flight.
         S_DRAIN: if (last_hs) state_nxt = S_FIN;
         S_FIN: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         n_words   <= '0;
         addr_q    <= '0;
         out_cnt   <= '0;
         cfg_err_q <= 1'b0;
         vld_p1    <= 1'b0;
      end else begin
         state  <= state_nxt;
         vld_p1 <= rd_en;
         if (take) begin
            cfg_err_q <= 1'b0;
            n_words   <= '0;
            addr_q    <= '0;
            out_cnt   <= '0;
         end
         if (state == S_CALC && (cfg_bad || (!div_step && n_bad))) begin
            cfg_err_q <= 1'b1;
            n_words   <= '0;
         end else if (state == S_CALC && !div_step) begin
            n_words <= NW'(prod);
         end
         if (rd_en) addr_q  <= addr_q + NW'(1);
         if (pop)   out_cnt <= out_cnt + NW'(1);
      end
   end

   // p0: configuration latch and repeated-subtraction divider
   always_ff @(posedge clk) begin
      if (take) begin
         tensor_q <= tensor_size;
         kernel_q <= kernel_size;
         stride_q <= stride;
         kn_q     <= kernel_nums;
         relu_q   <= relu_en;
         rem_q    <= tensor_size - TENSOR_W'(kernel_size);
         quot_q   <= '0;
      end else if (state == S_CALC && !cfg_bad && div_step) begin
         rem_q  <= rem_q - TENSOR_W'(stride_q);
         quot_q <= quot_q + TENSOR_W'(1);
      end
   end

   // p1: RAM word returns, is transformed and enters the FIFO
   assign data_p1 = saturate(relu($signed(rd_data), relu_q));

   sync_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (vld_p1),
      .push_data (data_p1),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );
endmodule

// File: doc/result_stream_out.md
# result_stream_out

Post-convolution readback stage that sits directly downstream of the convolution top. After the result-save RAM has been fully written (`w_done`), it reads that RAM sequentially and applies optional ReLU plus signed saturation to the output width. Results leave on a valid/ready stream with a last marker and a completion pulse. The block owns RAM port A only while busy; the top-level mux gives port A back to the write path otherwise.

## Interface
- `RESULT_SIZE`, default `` `RESULT_SIZE ``: width of a stored result word (signed).
- `OUT_WIDTH`, default 16: width of a streamed result (signed, saturated).
- `ADDR_SIZE`, default `` `ADDR_SIZE ``: RAM address width.
- `FIFO_DEPTH`, default 4: skid FIFO entries (power of two, at least 2).

- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse, driven from `w_done`.
- `relu_en` input 1: clamp negative results to 0; sampled at `start`.
- `tensor_size` input `` `TENSOR_SIZE ``: sampled at `start`.
- `kernel_size` input `` `KERNEL_SIZE ``: sampled at `start`.
- `stride` input `` `STRIDE_SIZE ``: sampled at `start`.
- `kernel_nums` input `` `KERNEL_NUMS_SIZE ``: sampled at `start`.
- `rd_en` output 1: RAM enable, read only.
- `rd_addr` output ADDR_SIZE: RAM address.
- `rd_data` input RESULT_SIZE: RAM data, valid exactly 1 cycle after `rd_en`.
- `m_valid` output 1: stream valid.
- `m_ready` input 1: stream ready.
- `m_data` output OUT_WIDTH: stream data.
- `m_last` output 1: qualifies the final word.
- `busy` output 1: high from the cycle after `start` until the `done` cycle inclusive.
- `done` output 1: one-cycle completion pulse.
- `cfg_err` output 1: sticky until the next `start`; flags a degenerate configuration.

## Operation
- FSM states: IDLE, CALC, READ, DRAIN, FIN.
- IDLE: when `start` is seen, latch the configuration, clear `cfg_err`, go to CALC. `start` is ignored in every other state.
- CALC computes `out = (tensor_size - kernel_size) / stride + 1` by repeated subtraction, one subtraction per cycle. It then computes `N = out*out*kernel_nums` in one cycle, using width ADDR_SIZE+1.
- Degenerate configuration: `stride==0`, `kernel_size>tensor_size`, `kernel_nums==0`, or N above 2^ADDR_SIZE. In that case set `cfg_err`, set N=0 and go to FIN with no reads.
- READ issues addresses 0..N-1 in order. A read is issued only when `fifo_count + inflight < FIFO_DEPTH`, where `inflight` is at most 1.
- Returning `rd_data` is transformed, then pushed into the FIFO. The transform is: ReLU if enabled, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- After address N-1 is issued, go to DRAIN. DRAIN waits for an empty FIFO and zero in-flight reads, then goes to FIN.
- FIN asserts `done` for 1 cycle, then returns to IDLE.
- `m_last` is high with the FIFO head word whose index is N-1.
- With N=0, no stream words are produced and `m_last` never asserts.

## Timing
- Reset value of every output is 0. The FIFO is emptied, counters cleared and the FSM returns to IDLE. A reset mid-transfer abandons the transfer and does not produce `done`.
- CALC length is q+1 cycles, where q is the quotient.
- First `rd_en` occurs in the cycle after CALC exits.
- The first `m_valid` occurs 2 cycles after the first `rd_en`: RAM latency, then the FIFO register.
- A handshake happens when `m_valid && m_ready`. Once `m_valid` is raised, `m_valid` and `m_data` hold until that handshake.
- With `m_ready` held high, throughput is one word per cycle with no bubbles after the first word.
- `m_ready` low: reads stall once the FIFO plus the in-flight read reach depth. Stall pressure never drops a word and never overflows the FIFO.
- Simultaneous push and pop on a full FIFO is legal and leaves the count unchanged.
- `done` rises 1 cycle after the `m_last` handshake. For the degenerate case, `done` rises 1 cycle after CALC detects the error.

## Structure
- The codebase's shared define file is the shared package. The stream/FSM state encodings and the saturation-limit constants are defined there.
- One natural sub-module: `sync_fifo` (parameterised width and depth; push, pop, full, empty, count).
- The CALC divider is inline in this block.

## Test plan
- tensor 5, kernel 3, stride 1, kernels 2, RAM[i]=i, `m_ready`=1 -> 18 words 0..17 on consecutive cycles, `m_last` on 17, `done` 1 cycle later.
- tensor 7, kernel 3, stride 2, kernels 1, `m_ready` toggling 1010… -> 9 words in order, none lost or duplicated, `rd_en` never issued with the FIFO plus the in-flight read at depth 4.
- RAM holds 100000, -100000 and -5; OUT_WIDTH 16; `relu_en` 0 then 1 -> 32767, -32768, -5 with ReLU off; 32767, 0, 0 with ReLU on.
- stride 0 or kernel 6 > tensor 5 -> `cfg_err`=1, no `rd_en`, no `m_valid`, `done` pulse.
- Reset asserted after 5 of 18 words -> all outputs 0 immediately. A new `start` afterwards restarts at address 0.
- `start` pulsed while busy -> ignored; output sequence identical to a run without the extra pulse.
